// File: rtl/simmem_wdata_tracker.sv
// Write-data beat tracker: queues AW descriptors, counts W beats against the head burst
// and issues one completion token per burst for the write delay calculator.
module simmem_wdata_tracker #(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned IidW      = 5,
  parameter int unsigned LenFieldW = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           aw_valid_i,
  output logic                           aw_ready_o,
  input  logic [IidW-1:0]                aw_iid_i,
  input  logic [LenFieldW-1:0]           aw_burst_len_i,
  input  logic                           w_valid_i,
  input  logic                           w_last_i,
  input  logic                           w_ready_i,
  output logic                           w_ready_o,
  output logic                           done_valid_o,
  output logic [IidW-1:0]                done_iid_o,
  input  logic                           done_ready_i,
  output logic [$clog2(FifoDepth+1)-1:0] pending_cnt_o,
  output logic                           last_err_o
);

  localparam int unsigned PtrW  = $clog2(FifoDepth);
  localparam int unsigned CntW  = $clog2(FifoDepth+1);
  localparam int unsigned BeatW = LenFieldW + 1;

  logic [IidW-1:0]      r_iid_mem [FifoDepth];
  logic [LenFieldW-1:0] r_len_mem [FifoDepth];
  logic [PtrW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic [BeatW-1:0]     r_beat;
  logic                 r_done_valid;
  logic [IidW-1:0]      r_done_iid;
  logic                 r_last_err;

  logic                 w_aw_fire;
  logic                 w_w_fire;
  logic                 w_stall;
  logic                 w_is_last_beat;
  logic                 w_final;
  logic [BeatW:0]       w_eff_m1;

  // One extra bit so eff_len = 1 << len never overflows before the subtraction.
  assign w_eff_m1       = ((BeatW+1)'(1) << r_len_mem[r_rd_ptr]) - (BeatW+1)'(1);
  assign w_is_last_beat = ({1'b0, r_beat} == w_eff_m1);

  assign w_stall    = r_done_valid & ~done_ready_i;
  assign aw_ready_o = (r_count != CntW'(FifoDepth));
  assign w_ready_o  = w_ready_i & (r_count != '0) & ~w_stall;
  assign w_aw_fire  = aw_valid_i & aw_ready_o;
  assign w_w_fire   = w_valid_i & w_ready_o;
  assign w_final    = w_w_fire & w_is_last_beat;

  always_ff @(posedge clk_i) begin
    if (w_aw_fire) begin
      r_iid_mem[r_wr_ptr] <= aw_iid_i;
      r_len_mem[r_wr_ptr] <= aw_burst_len_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_beat       <= '0;
      r_done_valid <= 1'b0;
      r_done_iid   <= '0;
      r_last_err   <= 1'b0;
    end else begin
      if (w_aw_fire) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_final)   r_rd_ptr <= r_rd_ptr + PtrW'(1);

      if (w_aw_fire && !w_final)      r_count <= r_count + CntW'(1);
      else if (!w_aw_fire && w_final) r_count <= r_count - CntW'(1);

      if (w_final)       r_beat <= '0;
      else if (w_w_fire) r_beat <= r_beat + BeatW'(1);

      // A new completion in the same cycle as a consume replaces the token.
      if (w_final) begin
        r_done_valid <= 1'b1;
        r_done_iid   <= r_iid_mem[r_rd_ptr];
      end else if (done_ready_i) begin
        r_done_valid <= 1'b0;
      end

      if (w_w_fire && (w_last_i != w_is_last_beat)) r_last_err <= 1'b1;
    end
  end

  assign done_valid_o  = r_done_valid;
  assign done_iid_o    = r_done_iid;
  assign pending_cnt_o = r_count;
  assign last_err_o    = r_last_err;

endmodule

// File: tb/tb_simmem_wdata_tracker.sv
// Directed bench for simmem_wdata_tracker: inputs driven 1 ns after the rising edge,
// outputs sampled 1 ns after the inputs settle.
module tb_simmem_wdata_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       aw_valid_i;
  logic       aw_ready_o;
  logic [4:0] aw_iid_i;
  logic [1:0] aw_burst_len_i;
  logic       w_valid_i;
  logic       w_last_i;
  logic       w_ready_i;
  logic       w_ready_o;
  logic       done_valid_o;
  logic [4:0] done_iid_o;
  logic       done_ready_i;
  logic [2:0] pending_cnt_o;
  logic       last_err_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  simmem_wdata_tracker #(
    .FifoDepth(4),
    .IidW     (5),
    .LenFieldW(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .aw_valid_i    (aw_valid_i),
    .aw_ready_o    (aw_ready_o),
    .aw_iid_i      (aw_iid_i),
    .aw_burst_len_i(aw_burst_len_i),
    .w_valid_i     (w_valid_i),
    .w_last_i      (w_last_i),
    .w_ready_i     (w_ready_i),
    .w_ready_o     (w_ready_o),
    .done_valid_o  (done_valid_o),
    .done_iid_o    (done_iid_o),
    .done_ready_i  (done_ready_i),
    .pending_cnt_o (pending_cnt_o),
    .last_err_o    (last_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic aw(input logic [4:0] iid, input logic [1:0] len);
    aw_valid_i = 1'b1; aw_iid_i = iid; aw_burst_len_i = len;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".aw_ready"}, aw_ready_o, 1);
    chk({tag, ".w_ready"}, w_ready_o, 0);
    chk({tag, ".done_valid"}, done_valid_o, 0);
    chk({tag, ".done_iid"}, done_iid_o, 0);
    chk({tag, ".pending"}, pending_cnt_o, 0);
    chk({tag, ".last_err"}, last_err_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; aw_valid_i = 0; aw_iid_i = 0; aw_burst_len_i = 0;
    w_valid_i = 0; w_last_i = 0; w_ready_i = 1; done_ready_i = 1;
    #1;
    chk_reset("reset");
    step(); step();
    rst_ni = 1'b1;

    // Two-beat burst, iid 3
    aw(3, 1);
    #1 chk("s1.w_ready_empty", w_ready_o, 0);
    step();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 0;
    #1 chk("s1.pending1", pending_cnt_o, 1);
    chk("s1.w_ready", w_ready_o, 1);
    step();
    w_last_i = 1;
    #1 chk("s1.no_done_yet", done_valid_o, 0);
    step();
    w_valid_i = 0;
    #1 chk("s1.done_valid", done_valid_o, 1);
    chk("s1.done_iid", done_iid_o, 3);
    chk("s1.pending0", pending_cnt_o, 0);
    chk("s1.last_err", last_err_o, 0);
    step();
    chk("s1.done_clear", done_valid_o, 0);

    // W ahead of AW is held off
    w_valid_i = 1; w_last_i = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("s2.hold_off", w_ready_o, 0);
      step();
    end
    aw(7, 0);
    #1 chk("s2.hold_same_cycle", w_ready_o, 0);
    step();
    aw_valid_i = 0;
    #1 chk("s2.w_ready_next", w_ready_o, 1);
    step();
    w_valid_i = 0;
    #1 chk("s2.done_valid", done_valid_o, 1);
    chk("s2.done_iid", done_iid_o, 7);
    step();

    // Fill FIFO; full refuses AW even while popping
    for (int i = 1; i <= 4; i++) begin
      aw(5'(i), 0);
      step();
    end
    aw(9, 0);
    #1 chk("s3.full_ready", aw_ready_o, 0);
    chk("s3.pending4", pending_cnt_o, 4);
    w_valid_i = 1; w_last_i = 1;
    step();
    aw_valid_i = 0; w_valid_i = 0;
    #1 chk("s3.ready_after_pop", aw_ready_o, 1);
    chk("s3.pending3", pending_cnt_o, 3);
    chk("s3.done_iid1", done_iid_o, 1);
    w_valid_i = 1;
    step();
    #1 chk("s3.done_iid2", done_iid_o, 2);
    step();
    #1 chk("s3.done_iid3", done_iid_o, 3);
    step();
    w_valid_i = 0;
    #1 chk("s3.done_iid4", done_iid_o, 4);
    chk("s3.pending0", pending_cnt_o, 0);
    step();

    // Token back-pressure stalls the next final beat
    done_ready_i = 0;
    aw(5, 0); step();
    aw(6, 0); step();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 1;
    #1 chk("s4.w_ready_free", w_ready_o, 1);
    step();
    #1 chk("s4.done_iid5", done_iid_o, 5);
    chk("s4.stall", w_ready_o, 0);
    step();
    #1 chk("s4.stall2", w_ready_o, 0);
    chk("s4.pending1", pending_cnt_o, 1);
    chk("s4.still_iid5", done_iid_o, 5);
    done_ready_i = 1;
    #1 chk("s4.unstall", w_ready_o, 1);
    step();
    w_valid_i = 0;
    #1 chk("s4.done_valid6", done_valid_o, 1);
    chk("s4.done_iid6", done_iid_o, 6);
    step();
    chk("s4.done_clear", done_valid_o, 0);

    // Early last flag: sticky error, counting follows length field
    aw(8, 2); step();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 0; step();
    w_last_i = 1; step();
    #1 chk("s5.err_set", last_err_o, 1);
    chk("s5.no_early_done", done_valid_o, 0);
    w_last_i = 0; step();
    #1 chk("s5.no_done_beat3", done_valid_o, 0);
    w_last_i = 1; step();
    w_valid_i = 0;
    #1 chk("s5.done_valid", done_valid_o, 1);
    chk("s5.done_iid", done_iid_o, 8);
    chk("s5.err_sticky", last_err_o, 1);
    step();

    // Reset mid-burst, then a fresh single-beat burst
    aw(9, 2); step();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 0; step();
    w_valid_i = 0; rst_ni = 0;
    #1 chk_reset("s6.mid_reset");
    step();
    rst_ni = 1;
    aw(10, 0); step();
    aw_valid_i = 0; w_valid_i = 1; w_last_i = 1; step();
    w_valid_i = 0;
    #1 chk("s6.done_valid", done_valid_o, 1);
    chk("s6.done_iid", done_iid_o, 10);
    chk("s6.last_err", last_err_o, 0);
    chk("s6.pending0", pending_cnt_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
